// File: rtl/output_drain_writer.sv
// -----------------------------------------------------------------------------
// output_drain_writer
//
// Purpose:
//   Drains one TILE_DIM x TILE_DIM tile of accumulator results into the output
//   buffer, one element per granted cycle, in row-major order. Element (r,c)
//   is written to base_addr + r*N + c (modulo 2^ADDR_WIDTH). Each accumulator
//   is narrowed to DATA_WIDTH bits on the way out.
//
// Configuration:
//   OUTPUT_DRAIN_SAT_EN  defined   -> signed saturation to DATA_WIDTH bits
//                        undefined -> truncation to the DATA_WIDTH LSBs
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous, active-high reset
//   start      in   single-cycle request to drain one tile (honoured in IDLE)
//   base_addr  in   buffer address of element (0,0)
//   N          in   row stride in elements (low ADDR_WIDTH bits are used)
//   tile_in    in   packed accumulators, element (r,c) at index r*TILE_DIM+c
//   mem_gnt    in   write grant from the output buffer arbiter
//   mem_cs     out  buffer chip select
//   mem_we     out  buffer write enable
//   mem_addr   out  buffer write address
//   mem_wdata  out  buffer write data
//   busy       out  high whenever not IDLE
//   done       out  one-cycle pulse after the last element is accepted
// -----------------------------------------------------------------------------
module output_drain_writer #(
    parameter int TILE_DIM   = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [ADDR_WIDTH-1:0]                      base_addr,
    input  logic [31:0]                                N,
    input  logic [TILE_DIM*TILE_DIM*2*DATA_WIDTH-1:0]  tile_in,
    input  logic                                       mem_gnt,
    output logic                                       mem_cs,
    output logic                                       mem_we,
    output logic [ADDR_WIDTH-1:0]                      mem_addr,
    output logic [DATA_WIDTH-1:0]                      mem_wdata,
    output logic                                       busy,
    output logic                                       done
);

    localparam int ACC_W    = 2 * DATA_WIDTH;
    localparam int NUM_ELEM = TILE_DIM * TILE_DIM;
    localparam int COL_W    = (TILE_DIM > 1) ? $clog2(TILE_DIM) : 1;
    localparam int IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(TILE_DIM - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [NUM_ELEM*ACC_W-1:0]   tile_q, tile_d;
    logic [ADDR_WIDTH-1:0]       stride_q, stride_d;
    // Address of column 0 of the current row; stepping it by the stride at
    // each row change avoids a multiplier in the address path.
    logic [ADDR_WIDTH-1:0]       row_base_q, row_base_d;
    logic [COL_W-1:0]            col_q, col_d;
    logic [IDX_W-1:0]            idx_q, idx_d;

    logic [ACC_W-1:0]            acc;
    logic [DATA_WIDTH-1:0]       conv;
    logic                        writing;

    // Only the low ADDR_WIDTH bits of the stride matter: addresses wrap anyway.
    generate
        if (ADDR_WIDTH < 32) begin : g_stride_hi
            logic unused_stride_hi;
            assign unused_stride_hi = ^N[31:ADDR_WIDTH];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: reset is synchronous and also clears the captured tile, so a
    // drain abandoned by reset leaves no stale data behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tile_q     <= '0;
            stride_q   <= '0;
            row_base_q <= '0;
            col_q      <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            tile_q     <= tile_d;
            stride_q   <= stride_d;
            row_base_q <= row_base_d;
            col_q      <= col_d;
            idx_q      <= idx_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every _d signal takes its hold value first so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        tile_d     = tile_q;
        stride_d   = stride_q;
        row_base_d = row_base_q;
        col_d      = col_q;
        idx_d      = idx_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tile_d     = tile_in;
                    stride_d   = N[ADDR_WIDTH-1:0];
                    row_base_d = base_addr;
                    col_d      = '0;
                    idx_d      = '0;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                // Advance only when the arbiter accepts the current element.
                if (mem_gnt) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (col_q == LAST_COL) begin
                            col_d      = '0;
                            row_base_d = row_base_q + stride_q;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Element select and narrowing
    // -------------------------------------------------------------------------
    assign acc = tile_q[idx_q*ACC_W +: ACC_W];

`ifdef OUTPUT_DRAIN_SAT_EN
    // The value fits in DATA_WIDTH signed bits exactly when the sign bit of
    // the result and every bit above it agree.
    logic [ACC_W-DATA_WIDTH:0] acc_hi;
    assign acc_hi = acc[ACC_W-1:DATA_WIDTH-1];

    always_comb begin
        if ((&acc_hi) || (~|acc_hi)) begin
            conv = acc[DATA_WIDTH-1:0];
        end else if (acc[ACC_W-1]) begin
            conv = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            conv = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    logic unused_acc_hi;
    assign unused_acc_hi = ^acc[ACC_W-1:DATA_WIDTH];
    assign conv          = acc[DATA_WIDTH-1:0];
`endif

    // -------------------------------------------------------------------------
    // Outputs: the bus is driven only in WRITE and is all-zero otherwise.
    // -------------------------------------------------------------------------
    assign writing   = (state_q == WRITE);
    assign mem_cs    = writing;
    assign mem_we    = writing;
    assign mem_addr  = writing ? (row_base_q + ADDR_WIDTH'(col_q)) : '0;
    assign mem_wdata = writing ? conv : '0;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule
